// File: rtl/axis_pkg.sv
// axis_pkg: shared FSM state encoding for the AXI-Stream packet generator.
package axis_pkg;
   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;
endpackage

// File: rtl/axis_packet_gen.sv
// axis_packet_gen: AXI-Stream master emitting incrementing-data packets,
// single-shot or looped with a programmable idle gap, stoppable on packet boundaries.
module axis_packet_gen
   import axis_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 8,
   parameter int LEN_WIDTH        = 16,
   parameter int GAP_WIDTH        = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_start,
   input  logic                        i_stop,
   input  logic                        i_repeat,
   input  logic [LEN_WIDTH-1:0]        i_pkt_len,
   input  logic [GAP_WIDTH-1:0]        i_gap,
   input  logic [AXIS_TDATA_WIDTH-1:0] i_seed,
   input  logic                        i_tid,
   input  logic                        i_tdest,
   input  logic                        i_tuser,
   output logic                        o_busy,
   output logic                        o_done,
   output logic [LEN_WIDTH-1:0]        o_pkt_count,
   output logic                        o_m_axis_tvalid,
   input  logic                        i_m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] o_m_axis_tdata,
   output logic                        o_m_axis_tlast,
   output logic                        o_m_axis_tstrb,
   output logic                        o_m_axis_tkeep,
   output logic                        o_m_axis_tid,
   output logic                        o_m_axis_tdest,
   output logic                        o_m_axis_tuser
);
   localparam logic [LEN_WIDTH-1:0]        LEN_ONE  = LEN_WIDTH'(1);
   localparam logic [GAP_WIDTH-1:0]        GAP_ONE  = GAP_WIDTH'(1);
   localparam logic [AXIS_TDATA_WIDTH-1:0] DATA_ONE = AXIS_TDATA_WIDTH'(1);

   state_e                        state_q, state_d;
   logic [LEN_WIDTH-1:0]          len_q, len_d, beat_q, beat_d, pcnt_q, pcnt_d;
   logic [GAP_WIDTH-1:0]          gap_q, gap_d, gcnt_q, gcnt_d;
   logic [AXIS_TDATA_WIDTH-1:0]   data_q, data_d;
   logic [2:0]                    side_q, side_d;
   logic                          rpt_q, rpt_d, stop_q, stop_d;
   logic                          tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic                          hs, stop_now;

   assign hs       = tvalid_q & i_m_axis_tready;
   assign stop_now = stop_q | i_stop;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      beat_d   = beat_q;
      pcnt_d   = pcnt_q;
      gap_d    = gap_q;
      gcnt_d   = gcnt_q;
      data_d   = data_q;
      side_d   = side_q;
      rpt_d    = rpt_q;
      stop_d   = stop_q | (i_stop & (state_q != IDLE));
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      unique case (state_q)
         IDLE: if (i_start && i_pkt_len != '0) begin
            state_d  = SEND;
            len_d    = i_pkt_len;
            gap_d    = i_gap;
            data_d   = i_seed;
            rpt_d    = i_repeat;
            side_d   = {i_tid, i_tdest, i_tuser};
            beat_d   = '0;
            tvalid_d = 1'b1;
            tlast_d  = i_pkt_len == LEN_ONE;
         end
         SEND: if (hs) begin
            // data keeps counting across packet boundaries so repeats stay continuous
            data_d  = data_q + DATA_ONE;
            beat_d  = beat_q + LEN_ONE;
            tlast_d = beat_q + LEN_ONE == len_q - LEN_ONE;
            if (tlast_q) begin
               pcnt_d = pcnt_q + LEN_ONE;
               beat_d = '0;
               if (rpt_q && !stop_now && gap_q == '0) begin
                  tlast_d = len_q == LEN_ONE;
               end else begin
                  state_d  = (rpt_q && !stop_now) ? GAP : DONE;
                  gcnt_d   = gap_q;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
               end
            end
         end
         GAP: if (stop_now) begin
            state_d = DONE;
         end else if (gcnt_q == GAP_ONE) begin
            state_d  = SEND;
            tvalid_d = 1'b1;
            tlast_d  = len_q == LEN_ONE;
         end else begin
            gcnt_d = gcnt_q - GAP_ONE;
         end
         DONE: begin
            state_d = IDLE;
            stop_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         len_q    <= '0;
         beat_q   <= '0;
         pcnt_q   <= '0;
         gap_q    <= '0;
         gcnt_q   <= '0;
         data_q   <= '0;
         side_q   <= '0;
         rpt_q    <= 1'b0;
         stop_q   <= 1'b0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         pcnt_q   <= pcnt_d;
         gap_q    <= gap_d;
         gcnt_q   <= gcnt_d;
         data_q   <= data_d;
         side_q   <= side_d;
         rpt_q    <= rpt_d;
         stop_q   <= stop_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

   assign o_busy          = state_q != IDLE;
   assign o_done          = state_q == DONE;
   assign o_pkt_count     = pcnt_q;
   assign o_m_axis_tvalid = tvalid_q;
   assign o_m_axis_tdata  = data_q;
   assign o_m_axis_tlast  = tlast_q;
   assign o_m_axis_tstrb  = tvalid_q;
   assign o_m_axis_tkeep  = tvalid_q;
   assign {o_m_axis_tid, o_m_axis_tdest, o_m_axis_tuser} = side_q;
endmodule

// File: tb/tb_axis_packet_gen.sv
// tb_axis_packet_gen: scoreboard bench; runs push expected beats, a negedge monitor pops and compares.
module tb_axis_packet_gen;
   typedef struct {
      logic [7:0] data;
      logic       last, id, de, us;
      int         gapb;
   } beat_t;

   logic        clk = 0, rst_n = 0, start = 0, stop = 0, rpt = 0, tready = 0;
   logic        tid = 0, tdest = 0, tuser = 0;
   logic [15:0] plen = 0;
   logic [7:0]  gap = 0, seed = 0;
   logic        busy, done, tvalid, tlast, tstrb, tkeep, otid, otdest, otuser;
   logic [15:0] pcnt;
   logic [7:0]  tdata;

   beat_t       q[$];
   beat_t       e;
   int          n_cmp = 0, n_fail = 0, hs_cnt = 0, done_cnt = 0, idle_run = 0, seg_gap = 0, tmode = 0;
   logic        prev_stall = 0, prev_valid = 0, prev_done = 0;
   logic [11:0] prev_out = 0;
   logic [15:0] exp_pkts = 0;

   axis_packet_gen dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_repeat(rpt),
      .i_pkt_len(plen), .i_gap(gap), .i_seed(seed), .i_tid(tid), .i_tdest(tdest), .i_tuser(tuser),
      .o_busy(busy), .o_done(done), .o_pkt_count(pcnt), .o_m_axis_tvalid(tvalid),
      .i_m_axis_tready(tready), .o_m_axis_tdata(tdata), .o_m_axis_tlast(tlast),
      .o_m_axis_tstrb(tstrb), .o_m_axis_tkeep(tkeep), .o_m_axis_tid(otid),
      .o_m_axis_tdest(otdest), .o_m_axis_tuser(otuser)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      tready = (tmode == 0) ? 1'b1 : (tmode == 1) ? ~tready : 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
         prev_valid = 0;
         prev_done  = 0;
         idle_run   = 0;
      end else begin
         if (prev_stall) chk("hold_stable", {tvalid, tdata, tlast, otid, otdest, otuser}, {1'b1, prev_out});
         if (tvalid && !prev_valid) seg_gap = idle_run;
         idle_run = tvalid ? 0 : busy ? idle_run + 1 : 0;
         if (tvalid && tready) begin
            hs_cnt++;
            if (q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_beat: got data %0h with no beat expected", tdata);
            end else begin
               e = q.pop_front();
               chk("beat", {tdata, tlast, otid, otdest, otuser, tkeep, tstrb},
                   {e.data, e.last, e.id, e.de, e.us, 2'b11});
               if (e.gapb >= 0) chk("gap_before_pkt", 64'(seg_gap), 64'(e.gapb));
            end
         end
         prev_stall = tvalid && !tready;
         prev_out   = {tdata, tlast, otid, otdest, otuser};
         prev_valid = tvalid;
         if (done) begin
            done_cnt++;
            chk("done_single_pulse", prev_done, 0);
         end
         prev_done = done;
      end
   end

   task automatic push_pkts(input int len, input int g, input int sd, input int np, input logic [2:0] sb);
      beat_t b;
      for (int p = 0; p < np; p++)
         for (int k = 0; k < len; k++) begin
            b.data = 8'(sd + p * len + k);
            b.last = k == len - 1;
            {b.id, b.de, b.us} = sb;
            b.gapb = (k != 0) ? -1 : (p == 0) ? 0 : g;
            q.push_back(b);
         end
   endtask

   task automatic wait_hs(input int thr);
      for (int c = 0; c < 3000 && hs_cnt < thr; c++) @(hs_cnt or posedge clk);
      chk("handshake_reached", 64'(hs_cnt >= thr), 1);
   endtask

   task automatic wait_done(input int d0);
      for (int c = 0; c < 3000 && done_cnt <= d0; c++) @(done_cnt or posedge clk);
      chk("done_reached", 64'(done_cnt > d0), 1);
   endtask

   task automatic go(input int len, input int g, input int sd, input bit r, input logic [2:0] sb);
      @(posedge clk);
      #2;
      plen = 16'(len);
      gap = 8'(g);
      seed = 8'(sd);
      rpt = r;
      {tid, tdest, tuser} = sb;
      start = 1;
      @(posedge clk);
      #2;
      start = 0;
   endtask

   // sdly < 0: no stop; 0: stop once packet np has begun; > 0: stop that many cycles into the first gap
   task automatic run(input int len, input int g, input int sd, input bit r, input int np,
                      input bit poke, input int sdly);
      logic [2:0] sb = 3'($urandom);
      int base = hs_cnt, d0 = done_cnt;
      push_pkts(len, g, sd, np, sb);
      go(len, g, sd, r, sb);
      chk("start_latency", tvalid, 1);
      if (poke) begin
         start = 1;
         plen = 2;
         seed = ~seed;
         rpt = ~r;
         @(posedge clk);
         #2;
         start = 0;
      end
      if (sdly >= 0) begin
         wait_hs(sdly == 0 ? base + (np - 1) * len + 1 : base + len);
         if (sdly > 0) begin
            repeat (sdly) @(posedge clk);
            #2;
         end
         stop = 1;
      end
      wait_done(d0);
      stop = 0;
      exp_pkts += 16'(np);
      chk("pkt_count", pcnt, exp_pkts);
      chk("handshake_total", 64'(hs_cnt - base), 64'(np * len));
      chk("queue_drained", 64'(q.size()), 0);
      @(posedge clk);
      #2;
      chk("idle_after_done", {busy, done, tvalid}, 0);
   endtask

   initial begin
      int len, g;
      bit r;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_state", {tvalid, tlast, tdata, otid, otdest, otuser, busy, done, pcnt}, 0);
      rst_n = 1;
      run(4, 0, 'hFE, 0, 1, 0, -1);
      tmode = 1;
      run(3, 0, 'h5A, 0, 1, 0, -1);
      tmode = 0;
      run(2, 3, 0, 1, 2, 0, 0);
      run(1, 0, 'h7C, 1, 6, 0, 0);
      run(2, 5, 'h10, 1, 1, 0, 2);
      go(0, 0, 'h33, 0, 3'b111);
      chk("len0_ignored", {tvalid, busy}, 0);
      @(posedge clk);
      #2;
      chk("len0_still_idle", {tvalid, busy, pcnt}, {2'b00, exp_pkts});
      tmode = 1;
      run(6, 0, 'hC0, 0, 1, 1, -1);
      tmode = 0;
      begin
         int base = hs_cnt;
         push_pkts(5, 0, 'h20, 1, 3'b101);
         go(5, 0, 'h20, 0, 3'b101);
         wait_hs(base + 2);
         rst_n = 0;
         #1;
         chk("reset_mid_outputs", {tvalid, tlast, tdata, otid, otdest, otuser, tkeep, tstrb, busy, done}, 0);
         chk("reset_mid_count", pcnt, 0);
         q.delete();
         exp_pkts = 0;
         repeat (2) @(posedge clk);
         #3;
         rst_n = 1;
      end
      run(3, 0, 'hA0, 0, 1, 0, -1);
      tmode = 2;
      for (int i = 0; i < 25; i++) begin
         len = $urandom_range(1, 6);
         g = $urandom_range(0, 4);
         r = 1'($urandom_range(0, 1));
         run(len, g, $urandom, r, r ? $urandom_range(1, 3) : 1, 0, r ? 0 : -1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
